// File: rtl/riscv_redirect_pkg.sv
// Shared types for the PC-redirect scheduler: FSM state and redirect source encodings.
package riscv_redirect_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CFLUSH   = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } redirect_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BU   = 2'd1,
    SRC_ST   = 2'd2,
    SRC_DU   = 2'd3
  } redirect_src_t;

  localparam int unsigned DRAIN_CNT_W = 4;

endpackage

// File: rtl/riscv_redirect_stats.sv
// Per-source counters of completed IF redirect handshakes; wrap at 2^32-1.
module riscv_redirect_stats
  import riscv_redirect_pkg::*;
(
  input  logic          rstn,
  input  logic          clk,
  input  logic          hs_i,
  input  redirect_src_t src_i,
  output logic [31:0]   stat_bu_cnt,
  output logic [31:0]   stat_st_cnt,
  output logic [31:0]   stat_du_cnt
);

  logic [31:0] bu_cnt_q, bu_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;
  logic [31:0] du_cnt_q, du_cnt_d;

  always_comb begin
    bu_cnt_d = bu_cnt_q;
    st_cnt_d = st_cnt_q;
    du_cnt_d = du_cnt_q;
    if (hs_i) begin
      unique case (src_i)
        SRC_BU:  bu_cnt_d = bu_cnt_q + 32'd1;
        SRC_ST:  st_cnt_d = st_cnt_q + 32'd1;
        SRC_DU:  du_cnt_d = du_cnt_q + 32'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bu_cnt_q <= '0;
      st_cnt_q <= '0;
      du_cnt_q <= '0;
    end else begin
      bu_cnt_q <= bu_cnt_d;
      st_cnt_q <= st_cnt_d;
      du_cnt_q <= du_cnt_d;
    end
  end

  assign stat_bu_cnt = bu_cnt_q;
  assign stat_st_cnt = st_cnt_q;
  assign stat_du_cnt = du_cnt_q;

endmodule

// File: rtl/riscv_redirect_ctrl.sv
// PC-redirect scheduler: du > st > bu arbitration, FENCE.I cache flush, IF handshake, drain.
// Optional redirect counters are built when RV_REDIRECT_STATS_EN is defined.
module riscv_redirect_ctrl
  import riscv_redirect_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] PC_INIT      = 'h200,
  parameter int unsigned     DRAIN_CYCLES = 2
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic            du_redirect,
  input  logic [XLEN-1:0] du_pc,
  input  logic            st_redirect,
  input  logic [XLEN-1:0] st_pc,
  input  logic            bu_flush,
  input  logic            bu_cacheflush,
  input  logic [XLEN-1:0] bu_nxt_pc,
  output logic            if_redirect_valid,
  input  logic            if_redirect_ready,
  output logic [XLEN-1:0] if_redirect_pc,
  output logic [1:0]      if_redirect_src,
  output logic            pipe_flush,
  output logic            ic_flush_req,
  input  logic            ic_flush_ack,
  output logic            busy,
  output logic [31:0]     stat_bu_cnt,
  output logic [31:0]     stat_st_cnt,
  output logic [31:0]     stat_du_cnt
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT =
    (DRAIN_CYCLES == 0) ? '0 : DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  redirect_state_t        state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  redirect_src_t          src_q, src_d;
  logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic [1:0]             src_out_q, src_out_d;
  logic                   pipe_flush_q, pipe_flush_d;
  logic                   ic_flush_req_q, ic_flush_req_d;
  logic                   busy_q, busy_d;

  logic            hi_req;
  logic [XLEN-1:0] hi_pc;
  redirect_src_t   hi_src;
  logic            hs;

  // du and st share one arbitration slot; bu is only considered from IDLE.
  assign hi_req = du_redirect | st_redirect;
  assign hi_pc  = du_redirect ? du_pc : st_pc;
  assign hi_src = du_redirect ? SRC_DU : SRC_ST;
  assign hs     = valid_q & if_redirect_ready;

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    src_d   = src_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (hi_req) begin
          state_d = REDIRECT;
          pc_d    = hi_pc;
          src_d   = hi_src;
        end else if (bu_flush) begin
          state_d = bu_cacheflush ? CFLUSH : REDIRECT;
          pc_d    = bu_nxt_pc;
          src_d   = SRC_BU;
        end
      end
      CFLUSH: begin
        if (hi_req) begin
          pc_d  = hi_pc;
          src_d = hi_src;
        end
        if (ic_flush_ack) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (hs) begin
          if (hi_req) begin
            pc_d  = hi_pc;
            src_d = hi_src;
          end else if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            cnt_d   = DRAIN_INIT;
          end
        end else if (hi_req && (logic'(1'b1) && (2'(hi_src) >= 2'(src_q)))) begin
          pc_d  = hi_pc;
          src_d = hi_src;
        end
      end
      DRAIN: begin
        if (hi_req) begin
          state_d = REDIRECT;
          pc_d    = hi_pc;
          src_d   = hi_src;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered one cycle later.
    valid_d        = (state_d == REDIRECT);
    src_out_d      = valid_d ? 2'(src_d) : 2'(SRC_NONE);
    pipe_flush_d   = (state_d != IDLE);
    ic_flush_req_d = (state_d == CFLUSH);
    busy_d         = (state_d != IDLE);
  end

  // NOTE: sequential state updates use non-blocking assignments only.
  // NOTE: reset comes up mid-redirect so IF fetches from PC_INIT as a trap-sourced target.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= REDIRECT;
      pc_q           <= PC_INIT;
      src_q          <= SRC_ST;
      cnt_q          <= '0;
      valid_q        <= 1'b1;
      src_out_q      <= 2'(SRC_ST);
      pipe_flush_q   <= 1'b1;
      ic_flush_req_q <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      src_q          <= src_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
      src_out_q      <= src_out_d;
      pipe_flush_q   <= pipe_flush_d;
      ic_flush_req_q <= ic_flush_req_d;
      busy_q         <= busy_d;
    end
  end

  assign if_redirect_valid = valid_q;
  assign if_redirect_pc    = pc_q;
  assign if_redirect_src   = src_out_q;
  assign pipe_flush        = pipe_flush_q;
  assign ic_flush_req      = ic_flush_req_q;
  assign busy              = busy_q;

`ifdef RV_REDIRECT_STATS_EN
  riscv_redirect_stats u_stats (
    .rstn        (rstn),
    .clk         (clk),
    .hs_i        (hs),
    .src_i       (src_q),
    .stat_bu_cnt (stat_bu_cnt),
    .stat_st_cnt (stat_st_cnt),
    .stat_du_cnt (stat_du_cnt)
  );
`else
  assign stat_bu_cnt = '0;
  assign stat_st_cnt = '0;
  assign stat_du_cnt = '0;
`endif

endmodule

// File: doc/riscv_redirect_ctrl.md
Name: riscv_redirect_ctrl

Overview:
- Central PC-redirect scheduler between the execute-stage branch unit, the state/trap unit, the debug unit and instruction fetch.
- Arbitrates simultaneous redirect requests by fixed priority.
- Sequences an optional I-cache flush (FENCE.I), issues a single registered redirect to IF over a valid/ready handshake, then holds the pipeline flush long enough to drain squashed instructions.

Parameters:
- XLEN, 32, PC and data width.
- PC_INIT, 'h200, PC issued on the first redirect after reset.
- DRAIN_CYCLES, 2, cycles pipe_flush stays high after the IF handshake; range 0..15.

Ports:
- rstn  in  1  async active-low reset
- clk  in  1  clock
- du_redirect  in  1  debug unit wrote NPC; single-cycle pulse
- du_pc  in  XLEN  debug NPC
- st_redirect  in  1  trap/xRET redirect pulse
- st_pc  in  XLEN  trap/return target
- bu_flush  in  1  branch mispredict/JALR/FENCE.I redirect pulse
- bu_cacheflush  in  1  qualifies bu_flush as FENCE.I
- bu_nxt_pc  in  XLEN  branch unit target
- if_redirect_valid  out  1  redirect pending to IF
- if_redirect_ready  in  1  IF accepts redirect
- if_redirect_pc  out  XLEN  redirect target
- if_redirect_src  out  2  0=none, 1=bu, 2=st, 3=du
- pipe_flush  out  1  flush ID/EX/MEM
- ic_flush_req  out  1  I-cache invalidate request
- ic_flush_ack  in  1  single-cycle invalidate-done pulse
- busy  out  1  state != IDLE
- stat_bu_cnt, stat_st_cnt, stat_du_cnt  out  32 each  redirect counters (see Optional Feature)

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk.
- All outputs are registered. A request sampled at cycle t appears on the outputs at t+1.
- Priority is du > st > bu. Losers in the same cycle are dropped; the pipeline flush kills their sources.
- FSM states: IDLE, CFLUSH, REDIRECT, DRAIN. Encoded as riscv_redirect_pkg::redirect_state_t.
- Reset values:
  - state=REDIRECT, if_redirect_pc=PC_INIT, if_redirect_src=2 (st), if_redirect_valid=1, pipe_flush=1.
  - ic_flush_req=0, busy=1, counters=0.
- IDLE:
  - du or st request -> REDIRECT with the winner's pc/src.
  - bu_flush&~bu_cacheflush -> REDIRECT (src=1).
  - bu_flush&bu_cacheflush -> CFLUSH; latch bu_nxt_pc; ic_flush_req=1.
  - pipe_flush=1 in every state except IDLE.
- CFLUSH:
  - ic_flush_req is held until ic_flush_ack. Then ic_flush_req=0 next cycle and the FSM goes to REDIRECT with the latched pc.
  - A du/st request during CFLUSH replaces the latched pc/src. The flush itself is never aborted.
  - ack and du/st in the same cycle: the new pc wins.
- REDIRECT:
  - if_redirect_valid=1. pc and src are stable until if_redirect_valid&if_redirect_ready.
  - On handshake -> DRAIN (counter=DRAIN_CYCLES-1), or IDLE directly if DRAIN_CYCLES==0.
  - A du/st request while waiting overwrites pc/src if its priority is >= the current src, and stays in REDIRECT.
  - Handshake and a new du/st request in the same cycle: the handshake completes and the FSM re-enters REDIRECT with the new pc.
- DRAIN:
  - The counter decrements each cycle; at 0 -> IDLE and pipe_flush drops.
  - du/st request -> REDIRECT (restart).
- bu_flush is ignored in every state except IDLE; it originates from a squashed path.
- busy = (state != IDLE).
- if_redirect_src=0 whenever if_redirect_valid=0.

Optional Feature:
- Macro RV_REDIRECT_STATS_EN.
- Defined:
  - Three 32-bit counters increment on each completed IF handshake according to src. The reset redirect counts as st.
  - Counters wrap at 2^32-1 -> 0.
- Undefined: stat_* ports are driven constant 0 and no counter flops are built.

Decomposition:
- Shared package riscv_redirect_pkg holds:
  - redirect_state_t enum {IDLE, CFLUSH, REDIRECT, DRAIN}.
  - redirect_src_t enum {SRC_NONE=0, SRC_BU=1, SRC_ST=2, SRC_DU=3}.
- Sub-module riscv_redirect_stats contains the three counters. It is instantiated only under RV_REDIRECT_STATS_EN.
- The FSM and arbitration stay in the top module.

Test Plan:
- Reset release, ready=0 for 3 cycles then 1:
  - valid=1, pc='h200, src=2, pipe_flush=1 throughout.
  - After the handshake pipe_flush stays high 2 more cycles; busy=0 on the 3rd.
- IDLE, bu_flush=1, bu_nxt_pc='h1000, ready=1:
  - Next cycle valid=1, pc='h1000, src=1.
  - pipe_flush high for 3 cycles total (REDIRECT + 2 DRAIN).
- Same cycle du_redirect (du_pc='h8000), st_redirect ('h100) and bu_flush ('h1000):
  - pc='h8000, src=3; bu and st dropped; stat_du_cnt +1 only.
- bu_flush+bu_cacheflush, pc='h2004; ack after 5 cycles:
  - ic_flush_req high 5 cycles, no valid during CFLUSH.
  - Then valid with pc='h2004.
- REDIRECT with bu pc='h1000, ready=0; st_redirect pc='h100:
  - pc switches to 'h100, src=2.
  - A later bu_flush is ignored; one handshake only.
- DRAIN_CYCLES=0, handshake cycle with no new requests:
  - Next cycle IDLE, pipe_flush=0.
  - Repeat with stats disabled: all stat_* read 0.
